// File: rtl/ternary_prog_loader_pkg.sv
// Shared definitions for the ternary program loader: trit encodings, framing
// constants, error codes and the loader state type.
package ternary_prog_loader_pkg;

    localparam logic [1:0] TRIT_ZERO    = 2'b00;
    localparam logic [1:0] TRIT_POS     = 2'b01;
    localparam logic [1:0] TRIT_NEG     = 2'b10;
    localparam logic [1:0] TRIT_INVALID = 2'b11;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_TRIT    = 3'd2;
    localparam logic [2:0] ERR_CSUM    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN,
        ST_B0,
        ST_B1,
        ST_B2,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    // Big-endian word assembly: only the low two bits of the first byte carry data.
    function automatic logic [17:0] assemble_word(input logic [7:0] b0,
                                                  input logic [7:0] b1,
                                                  input logic [7:0] b2);
        return {b0[1:0], b1, b2};
    endfunction

endpackage

// File: rtl/ternary_word_check.sv
// Combinational validity check of a 9-trit word: every 2-bit pair must hold a
// legal trit encoding.
module ternary_word_check
    import ternary_prog_loader_pkg::*;
(
    input  logic [17:0] word_i,
    output logic        valid_o
);

    always_comb begin
        valid_o = 1'b1;
        for (int t = 0; t < 9; t++) begin
            if (word_i[2*t +: 2] == TRIT_INVALID) begin
                valid_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ternary_prog_loader.sv
// Boot sequencer: parses framed byte stream, writes validated ternary words into
// imem through the program-load port, and releases the CPU after a good checksum.
module ternary_prog_loader
    import ternary_prog_loader_pkg::*;
#(
    parameter int IMEM_DEPTH     = 243,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        prog_mode,
    output logic [7:0]  prog_addr,
    output logic [17:0] prog_data,
    output logic        prog_we,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic [2:0]  err,
    output logic [7:0]  word_count
);

    localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] MAX_LEN = 8'(IMEM_DEPTH);

    loader_state_e state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    index_q, index_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    b0_q, b0_d;
    logic [7:0]    b1_q, b1_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          rx_ready_q, rx_ready_d;
    logic          prog_mode_q, prog_mode_d;
    logic [7:0]    prog_addr_q, prog_addr_d;
    logic [17:0]   prog_data_q, prog_data_d;
    logic          prog_we_q, prog_we_d;
    logic          cpu_rst_n_q, cpu_rst_n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [2:0]    err_q, err_d;
    logic [7:0]    word_count_q, word_count_d;

    logic          xfer;
    logic [17:0]   word_asm;
    logic          word_ok;

    assign xfer     = rx_valid && rx_ready_q;
    assign word_asm = assemble_word(b0_q, b1_q, rx_data);

    ternary_word_check u_word_check (
        .word_i  (word_asm),
        .valid_o (word_ok)
    );

    // Outputs are registered from the next state so each one is glitch-free and
    // lines up with the state it describes.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        index_d      = index_q;
        csum_d       = csum_q;
        b0_d         = b0_q;
        b1_d         = b1_q;
        tmo_d        = '0;
        prog_addr_d  = prog_addr_q;
        prog_data_d  = prog_data_q;
        prog_we_d    = 1'b0;
        err_d        = err_q;
        word_count_d = word_count_q;

        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (xfer && rx_data == LOADER_SYNC) begin
                    state_d      = ST_LEN;
                    err_d        = ERR_NONE;
                    word_count_d = '0;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN) begin
                        state_d = ST_ERR;
                        err_d   = ERR_LEN;
                    end else begin
                        len_d   = rx_data;
                        index_d = '0;
                        csum_d  = rx_data;
                        state_d = ST_B0;
                    end
                end
            end
            ST_B0: begin
                if (xfer) begin
                    b0_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_B1;
                end
            end
            ST_B1: begin
                if (xfer) begin
                    b1_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_B2;
                end
            end
            ST_B2: begin
                if (xfer) begin
                    csum_d = csum_q ^ rx_data;
                    if (b0_q[7:2] == 6'd0 && word_ok) begin
                        prog_we_d   = 1'b1;
                        prog_addr_d = index_q;
                        prog_data_d = word_asm;
                        state_d     = ST_WRITE;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_TRIT;
                    end
                end
            end
            ST_WRITE: begin
                index_d      = index_q + 8'd1;
                word_count_d = word_count_q + 8'd1;
                state_d      = (index_q + 8'd1 == len_q) ? ST_CSUM : ST_B0;
            end
            ST_CSUM: begin
                if (xfer) begin
                    if (rx_data == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_CSUM;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Mid-frame watchdog; any accepted byte restarts it.
        if ((state_q inside {ST_LEN, ST_B0, ST_B1, ST_B2, ST_CSUM}) && !xfer) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_ERR;
                err_d   = ERR_TIMEOUT;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        rx_ready_d  = !(state_d inside {ST_WRITE, ST_DONE});
        prog_mode_d = !(state_d inside {ST_IDLE, ST_DONE});
        cpu_rst_n_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            index_q      <= '0;
            csum_q       <= '0;
            b0_q         <= '0;
            b1_q         <= '0;
            tmo_q        <= '0;
            rx_ready_q   <= 1'b0;
            prog_mode_q  <= 1'b0;
            prog_addr_q  <= '0;
            prog_data_q  <= '0;
            prog_we_q    <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= ERR_NONE;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            index_q      <= index_d;
            csum_q       <= csum_d;
            b0_q         <= b0_d;
            b1_q         <= b1_d;
            tmo_q        <= tmo_d;
            rx_ready_q   <= rx_ready_d;
            prog_mode_q  <= prog_mode_d;
            prog_addr_q  <= prog_addr_d;
            prog_data_q  <= prog_data_d;
            prog_we_q    <= prog_we_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            word_count_q <= word_count_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign prog_mode  = prog_mode_q;
    assign prog_addr  = prog_addr_q;
    assign prog_data  = prog_data_q;
    assign prog_we    = prog_we_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = word_count_q;

endmodule

// File: doc/ternary_prog_loader.md
Name: ternary_prog_loader

Overview:
- Boot/program-load sequencer for the dual-issue ternary CPU system.
- Receives a framed byte stream (UART/JTAG bridge side) and validates the 2-bit trit encoding of each word.
- Drives the system's program-load port (prog_mode/prog_addr/prog_data/prog_we) while holding the CPU core in reset.
- Releases the CPU once a complete frame passes its checksum.

Parameters:
- IMEM_DEPTH, 243, max words per frame (must be ≤255).
- TIMEOUT_CYCLES, 1023, idle cycles without an accepted byte before abort (mid-frame only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  byte available
- rx_data  in  8  byte
- rx_ready  out  1  loader accepts byte; transfer = rx_valid && rx_ready
- prog_mode  out  1  to system prog_mode
- prog_addr  out  8  imem word address
- prog_data  out  18  9-trit word, 2 bits/trit
- prog_we  out  1  one-cycle write strobe
- cpu_rst_n  out  1  CPU reset, active-low, gated with system reset externally
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on successful load
- err  out  3  sticky error code: 0 none, 1 bad length, 2 bad trit/pad, 3 checksum, 4 timeout
- word_count  out  8  words written in current/last frame

Behaviour:
- Frame format: 0xA5 sync, LEN byte, LEN×3 word bytes, CSUM byte.
- Each word is big-endian: B0[1:0]=data[17:16] (B0[7:2] must be 0), B1=data[15:8], B2=data[7:0].
- CSUM = XOR of LEN and all word bytes.
- Trit encoding per ternary_defs.vh: 00=0, 01=+1, 10=−1, 11=invalid.
- Reset values: IDLE, rx_ready=0, prog_mode=0, prog_we=0, prog_addr=0, prog_data=0, cpu_rst_n=0, busy=0, done=0, err=0, word_count=0.
- First cycle after rst deasserts: cpu_rst_n=1, rx_ready=1.
- States:
  - IDLE: bytes other than 0xA5 are consumed and ignored. On 0xA5 → LEN. Next cycle: prog_mode=1, cpu_rst_n=0, err=0, word_count=0.
  - LEN: LEN=0 or LEN>IMEM_DEPTH → ERR(1); else latch N, clear index and checksum → B0.
  - B0 → B1 → B2: one byte each. On B2 accept, check pad bits and all 9 trit pairs. Any failure → ERR(2) with no write; otherwise → WRITE.
  - WRITE: exactly one cycle. prog_we=1, prog_addr=index, prog_data=assembled word, rx_ready=0. Then index++ and word_count++. Go to CSUM if index==N, else B0.
  - CSUM: byte matches → DONE; mismatch → ERR(3).
  - DONE: one cycle. done=1, prog_mode=0, rx_ready=0. Next cycle IDLE with cpu_rst_n=1.
  - ERR: err holds its code, prog_mode=1, cpu_rst_n=0, rx_ready=1. Bytes are drained. 0xA5 restarts at LEN with err cleared.
- Timeout applies in LEN/B0/B1/B2/CSUM only:
  - Counter clears on each accepted byte.
  - When the count reaches TIMEOUT_CYCLES → ERR(4).
- No rollback: words written before an error remain in imem, but the CPU stays in reset until a good frame completes.
- rx_valid held during WRITE/DONE is not consumed; the byte is taken on the next ready cycle.
- rst mid-frame: all outputs return to reset values on that edge; the partial frame is discarded.
- Checksum and error logic are 8-bit XOR. The index compare uses 8-bit unsigned arithmetic.

Decomposition:
- Add to ternary_defs.vh:
  - trit encodings
  - LOADER_SYNC=8'hA5
  - error code constants
  - state encodings
- Sub-module ternary_word_check: combinational, 18-bit word → valid flag (no 2'b11 pair). Reusable by other loaders.

Test Plan:
- Good frame: A5 02 00 00 01 01 12 40 50 → prog_we twice (addr0=18'h00001, addr1=18'h11240). Then done pulse, err=0, word_count=2, cpu_rst_n=1 the cycle after done.
- Length errors: A5 00 → err=1; A5 F4 → err=1. Neither produces a prog_we; cpu_rst_n stays 0.
- Bad trit: A5 02 00 00 01 00 00 03 → one write (addr0), then err=2, no second write. Pad error A5 01 04 00 00 → err=2.
- Bad checksum, then recovery:
  - A5 01 00 00 01 FF → err=3, prog_mode=1, CPU held in reset.
  - Follow with A5 01 00 00 01 00 → done pulse, err=0.
- Timeout with TIMEOUT_CYCLES=16: A5 03 then idle → err=4 exactly 16 cycles after LEN accept. No writes.
- Backpressure and reset:
  - rx_valid held high continuously → every WRITE and DONE cycle shows rx_ready=0, and no byte is lost or duplicated.
  - rst asserted after the first word → reset values next edge; a subsequent full frame loads correctly.
